spi_master: RTL and testbench
=============================

# spi_master

Host-side SPI initiator for the SPI-attached single-port RAM subsystem. Accepts one 10-bit command word per transaction over a valid/ready handshake, frames it with SS_n, shifts it MSB-first on MOSI (one bit per clk), and, for read-data commands, captures an 8-bit response from MISO and presents it with a one-cycle rd_valid pulse. Bits are launched and sampled on the system clock; no separate SCLK is generated.

## Interface

- TURN_CYCLES, 2, idle cycles between the last command bit and the first MISO sample (read-data only); legal range 1..15
- GAP_CYCLES, 1, minimum SS_n-high cycles after every frame before the next acceptance; legal range 1..15

- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  host presents cmd_word
- cmd_ready  out  1  high only in IDLE with rst_n=1
- cmd_word  in  10  [9:8] opcode (00 write addr, 01 write data, 10 read addr, 11 read data), [7:0] payload
- busy  out  1  high in every state except IDLE
- rd_data  out  8  last captured read byte; held until next capture
- rd_valid  out  1  one-cycle pulse when rd_data updates
- SS_n  out  1  frame select, active-low
- MOSI  out  1  serial command data
- MISO  in  1  serial response data

## Operation

- States: IDLE, START, SHIFT, TURN, READ, GAP.
- IDLE: SS_n=1, MOSI=0, cmd_ready=1. Acceptance = cmd_valid & cmd_ready at a rising edge; cmd_word latched into a 10-bit shift register; next state START.
- START (1 cycle): SS_n=0, MOSI=word[9] (direction bit). -> SHIFT.
- SHIFT (10 cycles): MOSI=word[9], word[8] … word[0] on successive cycles. After the 10th: opcode 11 -> TURN, else -> GAP.
- TURN (TURN_CYCLES cycles): SS_n=0, MOSI=0. -> READ.
- READ (8 cycles): SS_n=0, MOSI=0; MISO sampled at each rising edge, MSB first, into an 8-bit register. On the 8th sample: rd_data <= assembled byte, rd_valid=1 for the next cycle, -> GAP.
- GAP (GAP_CYCLES cycles): SS_n=1, MOSI=0. -> IDLE.
- cmd_word/cmd_valid ignored outside IDLE; no queuing.
- Bit counter 4 bits, counts down; TURN/GAP counters 4 bits.

## Timing

- Acceptance at edge E. SS_n low and MOSI=word[9] visible E+1; MOSI=word[9-i] at E+2+i (i=0..9).
- Write / read-address frame: SS_n low E+1..E+11 (11 cycles), high from E+12; cmd_ready high again at E+12+GAP_CYCLES.
- Read-data frame: MISO bit 7 sampled at edge E+12+TURN_CYCLES, bit 0 at E+19+TURN_CYCLES; rd_valid high in cycle E+20+TURN_CYCLES, coincident with SS_n going high.
- Defaults: write frame 13 cycles acceptance-to-ready; read-data frame 23 cycles.
- All outputs registered except cmd_ready, which decodes state and rst_n.
- Reset values: SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, busy=0, state IDLE; cmd_ready=0 while rst_n=0.
- Reset mid-frame: next edge forces the reset values; partial byte discarded, no rd_valid.
- cmd_valid held high continuously: back-to-back frames separated by exactly GAP_CYCLES SS_n-high cycles.

## Structure

- Package spi_pkg: opcode constants (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA), state enum, CMD_W=10, DATA_W=8.
- One sub-module: spi_master_shifter (10-bit parallel-load/serial-out for MOSI plus 8-bit serial-in for MISO, with load/shift enables). FSM and counters stay in spi_master.

## Test plan

- Write address 10'h0A5: MOSI sequence 0,0,0,1,0,1,0,0,1,0,1 on E+1..E+11; SS_n high at E+12; cmd_ready at E+13.
- Read data 10'h300 with MISO model driving 8'hC3 from edge E+14: rd_data=8'hC3, rd_valid single pulse at E+22, SS_n rises same cycle.
- cmd_valid held high with three queued words (0x0A5, 0x155, 0x2FF): exactly three frames, each separated by one SS_n-high cycle; cmd_word changes mid-frame have no effect.
- rst_n low at E+6 of a read-data frame: SS_n=1, MOSI=0 next edge, no rd_valid, rd_data stays 8'h00; next command frames correctly.
- TURN_CYCLES=4, GAP_CYCLES=3 build: read 10'h3FF returns MISO byte 8'h5A at rd_valid cycle E+24; next acceptance no earlier than E+27.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI RAM host initiator.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_TURN,
        ST_READ,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Command serializer (parallel-load, MSB-first out) and response deserializer.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [CMD_W-1:0]  load_word,
    input  logic              shift_en,
    output logic              mosi_bit,
    input  logic              sample_en,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_byte
);

    logic [CMD_W-1:0]  tx_q;
    logic [CMD_W-1:0]  tx_d;
    logic [DATA_W-2:0] rx_q;
    logic [DATA_W-2:0] rx_d;

    // The newest response bit is taken live so the full byte is ready on the final sample edge.
    assign rx_byte  = {rx_q, miso};
    assign mosi_bit = tx_q[CMD_W-1];

    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load) begin
            tx_d = load_word;
        end else if (shift_en) begin
            tx_d = {tx_q[CMD_W-2:0], 1'b0};
        end
        if (sample_en) begin
            rx_d = rx_byte[DATA_W-2:0];
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

endmodule

// File: rtl/spi_master.sv
// SPI host initiator: frames one 10-bit command per transaction, optionally reads back a byte.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_word,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rd_frame_q, rd_frame_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic        load;
    logic        shift_en;
    logic        sample_en;
    logic        mosi_bit;
    logic [7:0]  rx_byte;

    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign busy      = busy_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

    spi_master_shifter u_shifter (
        .clk       (clk),
        .load      (load),
        .load_word (cmd_word),
        .shift_en  (shift_en),
        .mosi_bit  (mosi_bit),
        .sample_en (sample_en),
        .miso      (MISO),
        .rx_byte   (rx_byte)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rd_frame_d = rd_frame_q;
        ss_n_d     = ss_n_q;
        mosi_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        load       = 1'b0;
        shift_en   = 1'b0;
        sample_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ss_n_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    load       = 1'b1;
                    rd_frame_d = (cmd_word[9:8] == OP_RD_DATA);
                    ss_n_d     = 1'b0;
                    mosi_d     = cmd_word[9];
                    state_d    = ST_START;
                end
            end
            // The direction bit is sent once more as the first SHIFT bit.
            ST_START: begin
                mosi_d    = mosi_bit;
                shift_en  = 1'b1;
                bit_cnt_d = 4'd9;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == 4'd0) begin
                    if (rd_frame_q) begin
                        wait_cnt_d = TURN_LOAD;
                        state_d    = ST_TURN;
                    end else begin
                        ss_n_d     = 1'b1;
                        wait_cnt_d = GAP_LOAD;
                        state_d    = ST_GAP;
                    end
                end else begin
                    mosi_d    = mosi_bit;
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            ST_TURN: begin
                if (wait_cnt_q == 4'd0) begin
                    bit_cnt_d = 4'd7;
                    state_d   = ST_READ;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_READ: begin
                sample_en = 1'b1;
                if (bit_cnt_q == 4'd0) begin
                    rd_data_d  = rx_byte;
                    rd_valid_d = 1'b1;
                    ss_n_d     = 1'b1;
                    wait_cnt_d = GAP_LOAD;
                    state_d    = ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                ss_n_d = 1'b1;
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: begin
                ss_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            wait_cnt_q <= 4'd0;
            rd_frame_q <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rd_frame_q <= rd_frame_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench: default build (TURN=2, GAP=1) and a TURN=4, GAP=3 build side by side.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_word = 10'h000;
    logic       miso = 1'b0;
    logic       sel = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [7:0] last_rd [2];

    logic       cv_a, cv_b;
    logic       rdy_a, rdy_b, busy_a, busy_b, rv_a, rv_b, ss_a, ss_b, mosi_a, mosi_b;
    logic [7:0] rd_a, rd_b;
    logic       o_rdy, o_busy, o_rv, o_ss, o_mosi;
    logic [7:0] o_rd;

    always #5 clk = ~clk;

    assign cv_a   = sel ? 1'b0 : cmd_valid;
    assign cv_b   = sel ? cmd_valid : 1'b0;
    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_rv   = sel ? rv_b   : rv_a;
    assign o_ss   = sel ? ss_b   : ss_a;
    assign o_mosi = sel ? mosi_b : mosi_a;
    assign o_rd   = sel ? rd_b   : rd_a;

    spi_master dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv_a), .cmd_ready(rdy_a), .cmd_word(cmd_word),
        .busy(busy_a), .rd_data(rd_a), .rd_valid(rv_a), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso)
    );

    spi_master #(.TURN_CYCLES(4), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv_b), .cmd_ready(rdy_b), .cmd_word(cmd_word),
        .busy(busy_b), .rd_data(rd_b), .rd_valid(rv_b), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso)
    );

    // Present a command to the selected instance; acceptance happens at the next rising edge.
    task automatic start(input logic s, input logic [9:0] w);
        @(negedge clk);
        sel = s;
        #1;
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept dut=%0d got=%b exp=1", s, o_rdy);
        end
        cmd_valid = 1'b1;
        cmd_word  = w;
    endtask

    // Reference frame: expected pins for every cycle k after acceptance edge E, from the timing rules.
    task automatic run_frame(input logic s, input logic [9:0] w, input logic [7:0] b,
                             input logic chain, input logic [9:0] nxt);
        int t, g, flen, last;
        logic r, e_ss, e_mosi, e_rv, e_busy, e_rdy;
        t = s ? 4 : 2;
        g = s ? 3 : 1;
        r = (w[9:8] == 2'b11);
        flen = r ? 19 + t : 11;
        last = flen + g + 1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            e_ss   = (k > flen);
            e_mosi = (k == 1) ? w[9] : ((k >= 2 && k <= 11) ? w[11-k] : 1'b0);
            e_rv   = r && (k == 20 + t);
            e_busy = (k <= flen + g);
            e_rdy  = (k == last);
            if (e_rv) last_rd[s] = b;
            checks += 6;
            if (o_ss !== e_ss) begin
                errors++; $display("FAIL ss_n dut=%0d w=%h k=%0d got=%b exp=%b", s, w, k, o_ss, e_ss);
            end
            if (o_mosi !== e_mosi) begin
                errors++; $display("FAIL mosi dut=%0d w=%h k=%0d got=%b exp=%b", s, w, k, o_mosi, e_mosi);
            end
            if (o_rv !== e_rv) begin
                errors++; $display("FAIL rd_valid dut=%0d w=%h k=%0d got=%b exp=%b", s, w, k, o_rv, e_rv);
            end
            if (o_rd !== last_rd[s]) begin
                errors++; $display("FAIL rd_data dut=%0d w=%h k=%0d got=%h exp=%h", s, w, k, o_rd, last_rd[s]);
            end
            if (o_busy !== e_busy) begin
                errors++; $display("FAIL busy dut=%0d w=%h k=%0d got=%b exp=%b", s, w, k, o_busy, e_busy);
            end
            if (o_rdy !== e_rdy) begin
                errors++; $display("FAIL cmd_ready dut=%0d w=%h k=%0d got=%b exp=%b", s, w, k, o_rdy, e_rdy);
            end
            // Inputs for the edge that ends cycle k.
            if (k == last) begin
                cmd_valid = chain;
                cmd_word  = chain ? nxt : 10'($urandom);
            end else begin
                cmd_valid = chain ? 1'b1 : 1'($urandom);
                cmd_word  = 10'($urandom);
            end
            if (r && k >= 12 + t && k <= 19 + t) miso = b[19+t-k];
            else miso = 1'($urandom);
        end
    endtask

    task automatic check_idle(input logic s, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks += 3;
            if (o_ss !== 1'b1) begin errors++; $display("FAIL idle_ss dut=%0d k=%0d got=%b exp=1", s, k, o_ss); end
            if (o_rv !== 1'b0) begin errors++; $display("FAIL idle_rv dut=%0d k=%0d got=%b exp=0", s, k, o_rv); end
            if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy dut=%0d k=%0d got=%b exp=0", s, k, o_busy); end
            miso = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checks += 6;
            if (o_ss !== 1'b1) begin errors++; $display("FAIL rst_ss dut=%0d got=%b exp=1", s, o_ss); end
            if (o_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi dut=%0d got=%b exp=0", s, o_mosi); end
            if (o_rv !== 1'b0) begin errors++; $display("FAIL rst_rv dut=%0d got=%b exp=0", s, o_rv); end
            if (o_rd !== 8'h00) begin errors++; $display("FAIL rst_rd_data dut=%0d got=%h exp=00", s, o_rd); end
            if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy dut=%0d got=%b exp=0", s, o_busy); end
            if (o_rdy !== 1'b0) begin errors++; $display("FAIL rst_ready dut=%0d got=%b exp=0", s, o_rdy); end
        end
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_addr();
        start(1'b0, 10'h0A5);
        run_frame(1'b0, 10'h0A5, 8'h00, 1'b0, 10'h000);
    endtask

    task automatic test_read_data();
        start(1'b0, 10'h300);
        run_frame(1'b0, 10'h300, 8'hC3, 1'b0, 10'h000);
    endtask

    task automatic test_random_frames(input logic s, input int n);
        logic [9:0] w;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            w = 10'($urandom);
            b = 8'($urandom);
            if (i % 2 == 0) w[9:8] = 2'b11;
            start(s, w);
            run_frame(s, w, b, 1'b0, 10'h000);
        end
    endtask

    task automatic test_back_to_back(input logic s);
        logic [9:0] words [4];
        words[0] = 10'h0A5; words[1] = 10'h155; words[2] = 10'h2FF; words[3] = 10'h000;
        start(s, words[0]);
        for (int i = 0; i < 3; i++) begin
            run_frame(s, words[i], 8'($urandom), (i < 2), words[i+1]);
        end
        check_idle(s, 6);
    endtask

    task automatic test_reset_mid_frame();
        start(1'b0, 10'h300);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom);
            cmd_word  = 10'($urandom);
            miso      = 1'($urandom);
            if (k == 6) rst_n = 1'b0;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        checks += 6;
        if (o_ss !== 1'b1) begin errors++; $display("FAIL midrst_ss got=%b exp=1", o_ss); end
        if (o_mosi !== 1'b0) begin errors++; $display("FAIL midrst_mosi got=%b exp=0", o_mosi); end
        if (o_rv !== 1'b0) begin errors++; $display("FAIL midrst_rv got=%b exp=0", o_rv); end
        if (o_rd !== 8'h00) begin errors++; $display("FAIL midrst_rd_data got=%h exp=00", o_rd); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        if (o_rdy !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", o_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(1'b0, 25);
        checks++;
        if (o_rd !== 8'h00) begin errors++; $display("FAIL midrst_rd_hold got=%h exp=00", o_rd); end
        start(1'b0, 10'h3A7);
        run_frame(1'b0, 10'h3A7, 8'($urandom), 1'b0, 10'h000);
    endtask

    task automatic test_long_turn();
        start(1'b1, 10'h3FF);
        run_frame(1'b1, 10'h3FF, 8'h5A, 1'b0, 10'h000);
        test_random_frames(1'b1, 4);
        test_back_to_back(1'b1);
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_data();
        test_random_frames(1'b0, 8);
        test_back_to_back(1'b0);
        test_reset_mid_frame();
        test_long_turn();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
